// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the legality check used by the
// datapath core and the request/response wrapper.
package alu_pkg;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  function automatic logic aluc_legal(input logic [2:0] aluc);
    return (aluc == ALUC_AND) || (aluc == ALUC_OR) || (aluc == ALUC_ADD) ||
           (aluc == ALUC_SUB) || (aluc == ALUC_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: evaluates one op and flags zero / illegal opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  input  logic [2:0]   aluc,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         err
);

  always_comb begin
    result = '0;
    unique case (aluc)
      ALUC_AND: result = src1 & src2;
      ALUC_OR:  result = src1 | src2;
      ALUC_ADD: result = src1 + src2;
      ALUC_SUB: result = src1 - src2;
      ALUC_SLT: result = {{(W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      default:  result = '0;
    endcase
  end

  // Illegal ops leave result at zero, so zero is asserted for them too.
  assign zero = (result == '0);
  assign err  = !aluc_legal(aluc);

endmodule

// File: rtl/alu_responder.sv
// Valid/ready wrapper around alu_core: results are queued in a small FIFO
// whose head is held in an output register; op and error counters saturate.
module alu_responder
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_src1,
  input  logic [W-1:0]     req_src2,
  input  logic [2:0]       req_aluc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = W + 2;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [EW-1:0]    head_reg, head_next;
  logic [CNT_W-1:0] op_count_reg, err_count_reg;

  logic [W-1:0]     core_result;
  logic             core_zero, core_err;
  logic [EW-1:0]    wr_entry;
  logic             push, pop;

  alu_core #(.W(W)) u_core (
    .src1   (req_src1),
    .src2   (req_src2),
    .aluc   (req_aluc),
    .result (core_result),
    .zero   (core_zero),
    .err    (core_err)
  );

  assign wr_entry  = {core_err, core_zero, core_result};
  assign req_ready = (count_reg != CW'(DEPTH));
  assign rsp_valid = (count_reg != '0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CW'(1);
    else if (pop && !push)
      count_next = count_reg - CW'(1);
  end

  assign rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

  // The head register tracks the slot at the next read pointer; when that
  // slot is being filled this very edge (queue drained to it), bypass the
  // write data. With nothing queued the last popped values are held.
  always_comb begin
    head_next = head_reg;
    if (count_next != '0)
      head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? wr_entry : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      head_reg      <= '0;
      op_count_reg  <= '0;
      err_count_reg <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      count_reg <= count_next;
      head_reg  <= head_next;
      if (push && !(&op_count_reg))
        op_count_reg <= op_count_reg + CNT_W'(1);
      if (push && core_err && !(&err_count_reg))
        err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

  assign rsp_result = head_reg[W-1:0];
  assign rsp_zero   = head_reg[W];
  assign rsp_err    = head_reg[W+1];
  assign op_count   = op_count_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_alu_responder.sv
// Directed bench for alu_responder: handshake, arithmetic, backpressure,
// streaming, illegal ops, counter saturation and mid-burst reset.
module tb_alu_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_src1, req_src2, rsp_result;
  logic [2:0]  req_aluc;
  logic        rsp_zero, rsp_err;
  logic [15:0] op_count, err_count;

  logic        r4_req_valid, r4_req_ready, r4_rsp_valid, r4_rsp_ready;
  logic [31:0] r4_src1, r4_src2, r4_rsp_result;
  logic [2:0]  r4_aluc;
  logic        r4_rsp_zero, r4_rsp_err;
  logic [3:0]  r4_op_count, r4_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_aluc(req_aluc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count), .err_count(err_count)
  );

  alu_responder #(.W(32), .DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r4_req_valid), .req_ready(r4_req_ready),
    .req_src1(r4_src1), .req_src2(r4_src2), .req_aluc(r4_aluc),
    .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rsp_ready),
    .rsp_result(r4_rsp_result), .rsp_zero(r4_rsp_zero), .rsp_err(r4_rsp_err),
    .op_count(r4_op_count), .err_count(r4_err_count)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Present one request for one cycle; caller guarantees req_ready is high.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_aluc = op; req_src1 = a; req_src2 = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: valid=%b result=%h zero=%b err=%b, required 0/0/0/0",
                         rsp_valid, rsp_result, rsp_zero, rsp_err);
    end
    checks++;
    if (op_count !== 16'd0 || err_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: op=%0d err=%0d, required 0/0", op_count, err_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
    $display("reset: released, req_ready=%b", req_ready);
  endtask

  task automatic test_arith;
    logic [2:0]  ops  [5] = '{3'b010, 3'b110, 3'b111, 3'b111, 3'b010};
    logic [31:0] as   [5] = '{32'd7, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] bs   [5] = '{32'd5, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] exps [5] = '{32'd12, 32'd0, 32'd1, 32'd0, 32'd0};
    logic        expz [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exps[i] || rsp_zero !== expz[i] || rsp_err !== 1'b0) begin
        errors++; $display("FAIL arith_%0d: valid=%b result=%h zero=%b err=%b, required 1/%h/%b/0",
                           i, rsp_valid, rsp_result, rsp_zero, rsp_err, exps[i], expz[i]);
      end
      $display("arith: op=%b a=%h b=%h -> result=%h zero=%b", ops[i], as[i], bs[i], rsp_result, rsp_zero);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd5) begin
      errors++; $display("FAIL arith_drain: valid=%b op_count=%0d, required 0/5", rsp_valid, op_count);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exps [3] = '{32'h30, 32'hFF, 32'd2};
    rsp_ready = 1'b0;
    issue(3'b000, 32'hF0, 32'h3C);
    issue(3'b001, 32'hF0, 32'h0F);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_full: req_ready=%b rsp_valid=%b, required 0/1", req_ready, rsp_valid);
    end
    req_valid = 1'b1; req_aluc = 3'b010; req_src1 = 32'd1; req_src2 = 32'd1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_result !== exps[0]) begin
        errors++; $display("FAIL bp_stall: req_ready=%b head=%h, required 0/%h", req_ready, rsp_result, exps[0]);
      end
    end
    $display("backpressure: head=%h held with queue full", rsp_result);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_result !== exps[1] || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_pop1: head=%h req_ready=%b, required %h/1", rsp_result, req_ready, exps[1]);
    end
    $display("backpressure: head=%h", rsp_result);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_result !== exps[2] || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_pop2: head=%h valid=%b, required %h/1", rsp_result, rsp_valid, exps[2]);
    end
    $display("backpressure: head=%h", rsp_result);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== exps[2] || op_count !== 16'd8) begin
      errors++; $display("FAIL bp_empty_hold: valid=%b result=%h op=%0d, required 0/%h/8",
                         rsp_valid, rsp_result, op_count, exps[2]);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op = legal[$urandom_range(0, 4)];
      a  = $urandom;
      b  = (i % 10 == 0) ? a : $urandom;
      req_valid = 1'b1; req_aluc = op; req_src1 = a; req_src2 = b;
      exp = ref_alu(op, a, b);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rsp_result !== exp ||
          rsp_zero !== (exp == 32'd0) || rsp_err !== 1'b0) begin
        errors++; $display("FAIL stream_%0d: valid=%b ready=%b result=%h zero=%b err=%b, required 1/1/%h/%b/0",
                           i, rsp_valid, req_ready, rsp_result, rsp_zero, rsp_err, exp, exp == 32'd0);
      end
      $display("stream %0d: op=%b a=%h b=%h -> %h", i, op, a, b, rsp_result);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd108) begin
      errors++; $display("FAIL stream_end: valid=%b op_count=%0d, required 0/108", rsp_valid, op_count);
    end
  endtask

  task automatic test_illegal;
    issue(3'b100, 32'd3, 32'd4);
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1 ||
        err_count !== 16'd1 || op_count !== 16'd109) begin
      errors++; $display("FAIL illegal_100: result=%h zero=%b err=%b errc=%0d opc=%0d, required 0/1/1/1/109",
                         rsp_result, rsp_zero, rsp_err, err_count, op_count);
    end
    $display("illegal: aluc=100 result=%h err=%b err_count=%0d", rsp_result, rsp_err, err_count);
    issue(3'b011, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1 || err_count !== 16'd2) begin
      errors++; $display("FAIL illegal_011: result=%h zero=%b err=%b errc=%0d, required 0/1/1/2",
                         rsp_result, rsp_zero, rsp_err, err_count);
    end
    $display("illegal: aluc=011 result=%h err=%b err_count=%0d", rsp_result, rsp_err, err_count);
    @(negedge clk);
  endtask

  task automatic test_saturate;
    r4_rsp_ready = 1'b1;
    r4_req_valid = 1'b1; r4_aluc = 3'b101; r4_src1 = 32'd3; r4_src2 = 32'd4;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 14) begin
        checks++;
        if (r4_op_count !== 4'd14 || r4_err_count !== 4'd14) begin
          errors++; $display("FAIL sat_14: op=%0d err=%0d, required 14/14", r4_op_count, r4_err_count);
        end
      end
    end
    r4_req_valid = 1'b0;
    checks++;
    if (r4_op_count !== 4'd15 || r4_err_count !== 4'd15) begin
      errors++; $display("FAIL sat_17: op=%0d err=%0d, required 15/15", r4_op_count, r4_err_count);
    end
    $display("saturate: 17 ops -> op_count=%0d err_count=%0d", r4_op_count, r4_err_count);
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    issue(3'b010, 32'd10, 32'd20);
    issue(3'b001, 32'd1, 32'd2);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_queued: req_ready=%b valid=%b, required 0/1", req_ready, rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || op_count !== 16'd0 || err_count !== 16'd0 ||
        r4_op_count !== 4'd0) begin
      errors++; $display("FAIL rstmid_async: valid=%b result=%h op=%0d err=%0d op4=%0d, required 0/0/0/0/0",
                         rsp_valid, rsp_result, op_count, err_count, r4_op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: req_ready=%b valid=%b, required 1/0", req_ready, rsp_valid);
    end
    $display("reset_mid: queue discarded, req_ready=%b", req_ready);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_src1 = '0; req_src2 = '0; req_aluc = '0; rsp_ready = 1'b0;
    r4_req_valid = 1'b0; r4_src1 = '0; r4_src2 = '0; r4_aluc = '0; r4_rsp_ready = 1'b0;
    test_reset;
    test_arith;
    test_backpressure;
    test_back_to_back;
    test_illegal;
    test_saturate;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
